mem_byte_sched: RTL

// Schedules the shared byte-wide RAM/IO bus between two requesters: instruction

---
 rtl/mem_byte_sched_pkg.sv | 40 ++++
 rtl/mem_byte_sched_byte_assembler.sv | 28 ++
 rtl/mem_byte_sched.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_byte_sched_pkg.sv
// Shared types and constants for the byte-serial memory bus scheduler.
// Covers the length codes, FSM/owner encodings and the default IO region select.
package mem_byte_sched_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_bus_t;
  typedef logic [MEM_DATA_W-1:0] mem_data_bus_t;

  localparam logic [2:0] LEN_BYTE = 3'd1;
  localparam logic [2:0] LEN_HALF = 3'd2;
  localparam logic [2:0] LEN_WORD = 3'd4;

  localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_DRAIN,
    ST_WR,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_MEM
  } owner_t;

  // Any length code other than 1 or 2 is handled as a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    case (len)
      LEN_BYTE: norm_len = LEN_BYTE;
      LEN_HALF: norm_len = LEN_HALF;
      default:  norm_len = LEN_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_sched_byte_assembler.sv
// Inserts a captured byte into its lane and produces the zero/sign-extended
// load result for the current transfer length.
module byte_assembler
  import mem_byte_sched_pkg::*;
(
  input  mem_data_bus_t word_in,
  input  logic [1:0]    lane,
  input  logic [7:0]    byte_in,
  input  logic [2:0]    len,
  input  logic          sgn,
  output mem_data_bus_t word_out,
  output mem_data_bus_t ext_out
);

  always_comb begin
    word_out = word_in;
    word_out[{lane, 3'b000} +: 8] = byte_in;
  end

  always_comb begin
    case (len)
      LEN_BYTE: ext_out = {{24{sgn & word_out[7]}}, word_out[7:0]};
      LEN_HALF: ext_out = {{16{sgn & word_out[15]}}, word_out[15:0]};
      default:  ext_out = word_out;
    endcase
  end

endmodule

// File: rtl/mem_byte_sched.sv
// Arbitrates the byte-wide RAM/IO bus between instruction fetch and the MEM stage,
// serialising 1/2/4-byte requests into pipelined (RAM) or one-at-a-time (IO) byte cycles.
module mem_byte_sched
  import mem_byte_sched_pkg::*;
#(
  parameter logic [1:0]  IO_SEL = IO_SEL_DEFAULT,
  parameter int unsigned ADDR_W = MEM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rdy,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_w_data,
  input  logic [7:0]        ram_r_data,
  input  logic              if_read,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_data,
  output logic              if_busy,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data_i,
  input  logic [2:0]        mem_length,
  input  logic              mem_signed,
  output logic              mem_ready,
  output logic [31:0]       mem_data_o,
  output logic              mem_busy
);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [2:0]          issue_q, issue_d, cap_q, cap_d, len_q, len_d;
  logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
  logic                sgn_q, sgn_d, is_io_q, is_io_d;
  mem_data_bus_t       wdata_q, wdata_d, buf_q, buf_d;
  logic                rd_iss_q, rd_iss_d, dvld_q, dvld_d, rw_q, rw_d;
  logic [7:0]          wbyte_q, wbyte_d;
  logic                if_rdy_q, if_rdy_d, mem_rdy_q, mem_rdy_d;
  mem_data_bus_t       if_data_q, if_data_d, mem_out_q, mem_out_d;
  logic                if_busy_q, if_busy_d, mem_busy_q, mem_busy_d;
  mem_data_bus_t       asm_word, asm_ext;

  byte_assembler u_asm (
    .word_in  (buf_q),
    .lane     (cap_q[1:0]),
    .byte_in  (ram_r_data),
    .len      (len_q),
    .sgn      (sgn_q),
    .word_out (asm_word),
    .ext_out  (asm_ext)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    issue_d   = issue_q;
    cap_d     = cap_q;
    len_d     = len_q;
    base_d    = base_q;
    sgn_d     = sgn_q;
    is_io_d   = is_io_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    rd_iss_d  = 1'b0;
    dvld_d    = rd_iss_q;
    rw_d      = 1'b0;
    addr_d    = addr_q;
    wbyte_d   = wbyte_q;
    if_rdy_d  = 1'b0;
    mem_rdy_d = 1'b0;
    if_data_d = if_data_q;
    mem_out_d = mem_out_q;

    if (!rdy) begin
      // In-flight reads are discarded; resume issuing from the last captured byte.
      issue_d = cap_q;
      dvld_d  = 1'b0;
      if (state_q == ST_RD_DRAIN) state_d = ST_RD_ISSUE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          issue_d = '0;
          cap_d   = '0;
          buf_d   = '0;
          if (mem_write || mem_read) begin
            owner_d = OWN_MEM;
            base_d  = mem_addr;
            len_d   = norm_len(mem_length);
            sgn_d   = mem_signed;
            wdata_d = mem_data_i;
            is_io_d = (mem_addr[17:16] == IO_SEL);
            state_d = mem_write ? ST_WR : ST_RD_ISSUE;
          end else if (if_read) begin
            owner_d = OWN_IF;
            base_d  = if_addr;
            len_d   = LEN_WORD;
            sgn_d   = 1'b0;
            is_io_d = (if_addr[17:16] == IO_SEL);
            state_d = ST_RD_ISSUE;
          end
        end

        ST_RD_ISSUE, ST_RD_DRAIN: begin
          if (owner_q == OWN_IF && !if_read) begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
            dvld_d  = 1'b0;
          end else begin
            if (dvld_q) begin
              buf_d = asm_word;
              cap_d = cap_q + 3'd1;
            end
            // IO reads wait until the previous byte's address has been consumed.
            if (state_q == ST_RD_ISSUE && issue_q < len_q && !(is_io_q && rd_iss_q)) begin
              addr_d   = base_q + ADDR_W'(issue_q);
              issue_d  = issue_q + 3'd1;
              rd_iss_d = 1'b1;
              if (issue_q + 3'd1 == len_q) state_d = ST_RD_DRAIN;
            end
            if (dvld_q && (cap_q + 3'd1 == len_q)) begin
              state_d = ST_DONE;
              if (owner_q == OWN_IF) begin
                if_rdy_d  = 1'b1;
                if_data_d = asm_ext;
              end else begin
                mem_rdy_d = 1'b1;
                mem_out_d = asm_ext;
              end
            end
          end
        end

        ST_WR: begin
          cap_d = cap_q + {2'b00, rw_q};
          if (issue_q < len_q) begin
            rw_d    = 1'b1;
            addr_d  = base_q + ADDR_W'(issue_q);
            wbyte_d = wdata_q[{issue_q[1:0], 3'b000} +: 8];
            issue_d = issue_q + 3'd1;
          end else if (cap_d == len_q) begin
            mem_rdy_d = 1'b1;
            state_d   = ST_DONE;
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end

        default: begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      endcase
    end

    if_busy_d  = (owner_d == OWN_MEM);
    mem_busy_d = (owner_d == OWN_IF);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      issue_q    <= '0;
      cap_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      sgn_q      <= 1'b0;
      is_io_q    <= 1'b0;
      wdata_q    <= '0;
      buf_q      <= '0;
      rd_iss_q   <= 1'b0;
      dvld_q     <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wbyte_q    <= '0;
      if_rdy_q   <= 1'b0;
      mem_rdy_q  <= 1'b0;
      if_data_q  <= '0;
      mem_out_q  <= '0;
      if_busy_q  <= 1'b0;
      mem_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      issue_q    <= issue_d;
      cap_q      <= cap_d;
      len_q      <= len_d;
      base_q     <= base_d;
      sgn_q      <= sgn_d;
      is_io_q    <= is_io_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      rd_iss_q   <= rd_iss_d;
      dvld_q     <= dvld_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wbyte_q    <= wbyte_d;
      if_rdy_q   <= if_rdy_d;
      mem_rdy_q  <= mem_rdy_d;
      if_data_q  <= if_data_d;
      mem_out_q  <= mem_out_d;
      if_busy_q  <= if_busy_d;
      mem_busy_q <= mem_busy_d;
    end
  end

  assign ram_rw     = rw_q & rdy;
  assign ram_addr   = addr_q;
  assign ram_w_data = wbyte_q;
  assign if_ready   = if_rdy_q;
  assign if_data    = if_data_q;
  assign if_busy    = if_busy_q;
  assign mem_ready  = mem_rdy_q;
  assign mem_data_o = mem_out_q;
  assign mem_busy   = mem_busy_q;

endmodule
